// File: rtl/async_fifo_pkg.sv
// rtl/async_fifo_pkg.sv - shared constants and pointer helpers for the async FIFO
// Purpose: default address width, pointer width, Gray encode and full-compare mask.
// Ports: none (package).
package async_fifo_pkg;

  localparam int ADDR_DEFAULT = 3;
  localparam int PTR_DEFAULT  = ADDR_DEFAULT + 1;

  // Binary to Gray; callers cast the result down to their pointer width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Mask that flips the top two bits of a ptr-bit Gray pointer. A Gray write
  // pointer exactly one depth ahead of the read pointer differs from it in
  // precisely those two bits.
  function automatic logic [31:0] full_mask(input int ptr);
    logic [31:0] m;
    m = '0;
    m[ptr-1] = 1'b1;
    m[ptr-2] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/gray_to_binary.sv
// rtl/gray_to_binary.sv - combinational Gray to binary converter
// Purpose: each binary bit is the XOR of all Gray bits at or above it.
// Ports: gray (input), bin (output), both PTR bits.
module gray_to_binary #(
  parameter int PTR = 4
) (
  input  logic [PTR-1:0] gray,
  output logic [PTR-1:0] bin
);

  always_comb begin
    bin = '0;
    for (int i = 0; i < PTR; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - parameterised two-flop synchroniser
// Purpose: bring a Gray-coded bus from another clock domain into clk.
// Ports: clk, rst (async active-high), d (async input), q (synchronised output).
module sync_2ff #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q1 <= '0;
      q  <= '0;
    end else begin
      q1 <= d;
      q  <= q1;
    end
  end

endmodule

// File: rtl/async_fifo_wptr_full.sv
// rtl/async_fifo_wptr_full.sv - write-domain pointer, full flag and fill count
// Purpose: owns the binary write pointer, exports its Gray copy, synchronises
//   the read Gray pointer and derives full, occupancy and overflow.
// Ports: clk, rst (async active-high), wr_en, rptr_gray_async (in);
//   wr_addr, wr_inc, wptr_gray, full, wr_count, overflow (out);
//   almost_full (out) exists only when ALMOST_FULL_EN is defined.
module async_fifo_wptr_full
  import async_fifo_pkg::*;
#(
  parameter int ADDR     = ADDR_DEFAULT,
  parameter int AF_LEVEL = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [ADDR:0]   rptr_gray_async,
  output logic [ADDR-1:0] wr_addr,
  output logic            wr_inc,
  output logic [ADDR:0]   wptr_gray,
  output logic            full,
  output logic [ADDR:0]   wr_count,
  output logic            overflow
`ifdef ALMOST_FULL_EN
  ,
  output logic            almost_full
`endif
);

  localparam int PTR = ADDR + 1;

  logic [PTR-1:0] wbin;
  logic [PTR-1:0] wbin_next;
  logic [PTR-1:0] wgray_next;
  logic [PTR-1:0] rq2;
  logic [PTR-1:0] rbin_s;
  logic [PTR-1:0] full_target;
  logic [PTR-1:0] fill_next;

  sync_2ff #(.W(PTR)) u_rptr_sync (
    .clk (clk),
    .rst (rst),
    .d   (rptr_gray_async),
    .q   (rq2)
  );

  gray_to_binary #(.PTR(PTR)) u_rptr_g2b (
    .gray (rq2),
    .bin  (rbin_s)
  );

  always_comb begin
    wr_inc      = wr_en & ~full;
    wbin_next   = wbin + PTR'(wr_inc);
    wgray_next  = PTR'(bin2gray(32'(wbin_next)));
    full_target = rq2 ^ PTR'(full_mask(PTR));
    // Uses the synchronised (stale) read pointer, so the count can only
    // overstate occupancy, never understate it.
    fill_next   = wbin_next - rbin_s;
  end

  assign wr_addr = wbin[ADDR-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbin      <= '0;
      wptr_gray <= '0;
      full      <= 1'b0;
      wr_count  <= '0;
      overflow  <= 1'b0;
    end else begin
      wbin      <= wbin_next;
      wptr_gray <= wgray_next;
      // Compared against the next pointer so full rises on the edge that
      // accepts the last free slot.
      full      <= (wgray_next == full_target);
      wr_count  <= fill_next;
      overflow  <= wr_en & full;
    end
  end

`ifdef ALMOST_FULL_EN
  localparam logic [PTR-1:0] AF_THR = PTR'(AF_LEVEL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      almost_full <= 1'b0;
    end else begin
      almost_full <= (fill_next >= AF_THR);
    end
  end
`endif

endmodule

// File: tb/tb_async_fifo_wptr_full.sv
// tb/tb_async_fifo_wptr_full.sv - self-checking bench for async_fifo_wptr_full
// Purpose: occupancy-level reference model plus directed literal checks.
// Ports: none (top-level bench); almost_full is exercised when ALMOST_FULL_EN is defined.
module tb_async_fifo_wptr_full;

  localparam int ADDR  = 3;
  localparam int PTR   = ADDR + 1;
  localparam int DEPTH = 1 << ADDR;
  localparam int MODP  = 1 << PTR;
  localparam int AFL   = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic            wr_en;
  logic [PTR-1:0]  rptr_gray_async;
  logic [ADDR-1:0] wr_addr;
  logic            wr_inc;
  logic [PTR-1:0]  wptr_gray;
  logic            full;
  logic [PTR-1:0]  wr_count;
  logic            overflow;
`ifdef ALMOST_FULL_EN
  logic            almost_full;
`endif

  async_fifo_wptr_full #(.ADDR(ADDR), .AF_LEVEL(AFL)) dut (
    .clk             (clk),
    .rst             (rst),
    .wr_en           (wr_en),
    .rptr_gray_async (rptr_gray_async),
    .wr_addr         (wr_addr),
    .wr_inc          (wr_inc),
    .wptr_gray       (wptr_gray),
    .full            (full),
    .wr_count        (wr_count),
    .overflow        (overflow)
`ifdef ALMOST_FULL_EN
    ,
    .almost_full     (almost_full)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int gray(input int b);
    return (b ^ (b >> 1)) & (MODP - 1);
  endfunction

  // Reference model: the write side accepts while its view of occupancy is
  // below DEPTH; that view uses the read pointer as driven two edges earlier.
  int rb;
  int m_wbin, m_cnt, m_s0, m_s1;
  bit m_full, m_ovf, m_af;

  always @(posedge clk or posedge rst) begin : model
    int inc, nw;
    if (rst) begin
      m_wbin = 0; m_cnt = 0; m_s0 = 0; m_s1 = 0;
      m_full = 0; m_ovf = 0; m_af = 0;
    end else begin
      inc    = (wr_en && !m_full) ? 1 : 0;
      nw     = (m_wbin + inc) % MODP;
      m_ovf  = wr_en && m_full;
      m_cnt  = (nw - m_s1) & (MODP - 1);
      m_full = (m_cnt == DEPTH);
      m_af   = (m_cnt >= AFL);
      m_wbin = nw;
      m_s1   = m_s0;
      m_s0   = rb;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("wptr_gray", int'(wptr_gray), gray(m_wbin));
      check("wr_addr",   int'(wr_addr),   m_wbin % DEPTH);
      check("full",      int'(full),      int'(m_full));
      check("wr_count",  int'(wr_count),  m_cnt);
      check("overflow",  int'(overflow),  int'(m_ovf));
      check("wr_inc",    int'(wr_inc),    int'(wr_en && !m_full));
`ifdef ALMOST_FULL_EN
      check("almost_full", int'(almost_full), int'(m_af));
`endif
    end
  end

  task automatic cyc(input bit we, input int rbv);
    wr_en = we;
    rb = rbv & (MODP - 1);
    rptr_gray_async = PTR'(gray(rb));
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr_en = 1'b0;
    rb = 0;
    rptr_gray_async = '0;
    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    bit seen_1000, wrapped, full_seen;
    int max_cnt, rdp;

    rst = 1'b1;
    wr_en = 1'b0;
    rb = 0;
    rptr_gray_async = '0;
    #1;
    check("rst0_wptr_gray", int'(wptr_gray), 0);
    check("rst0_full",      int'(full),      0);
    check("rst0_wr_count",  int'(wr_count),  0);
    check("rst0_overflow",  int'(overflow),  0);
    do_reset();

    // Fill from empty with the reader parked at 0.
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 0);
    check("t1_full",      int'(full),      1);
    check("t1_wr_count",  int'(wr_count),  8);
    check("t1_wptr_gray", int'(wptr_gray), 4'b1100);
    check("t1_wr_addr",   int'(wr_addr),   0);

    // Writes while full are dropped and flagged.
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 0);
      check("t2_overflow",  int'(overflow),  1);
      check("t2_wptr_gray", int'(wptr_gray), 4'b1100);
      check("t2_wr_count",  int'(wr_count),  8);
    end

    // Reader jumps to 3 (Gray 0010): visible on the third edge.
    cyc(1'b0, 3);
    check("t3_full_e1", int'(full), 1);
    cyc(1'b0, 3);
    check("t3_full_e2", int'(full), 1);
    cyc(1'b0, 3);
    check("t3_full_e3",  int'(full),     0);
    check("t3_count_e3", int'(wr_count), 5);

    // Streaming with the reader trailing closely; pointer wraps.
    do_reset();
    seen_1000 = 0; wrapped = 0; full_seen = 0; max_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, (i >= 1) ? i - 1 : 0);
      if (wptr_gray == 4'b1000) seen_1000 = 1;
      if (seen_1000 && wptr_gray == 4'b0000) wrapped = 1;
      if (full) full_seen = 1;
      if (int'(wr_count) > max_cnt) max_cnt = int'(wr_count);
    end
    check("t4_seen_1000",  int'(seen_1000),   1);
    check("t4_wrapped",    int'(wrapped),     1);
    check("t4_full_never", int'(full_seen),   0);
    check("t4_count_le4",  int'(max_cnt <= 4), 1);

    // Asynchronous reset mid-burst.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 0);
    check("t5_pre_wptr", int'(wptr_gray), gray(5));
    #1;
    wr_en = 1'b0;
    rst = 1'b1;
    #1;
    check("t5_rst_wptr_gray", int'(wptr_gray), 0);
    check("t5_rst_full",      int'(full),      0);
    check("t5_rst_wr_count",  int'(wr_count),  0);
    check("t5_rst_wr_addr",   int'(wr_addr),   0);
    rst = 1'b0;
    #1;
    check("t5_first_addr", int'(wr_addr), 0);
    cyc(1'b1, 0);
    check("t5_after_one", int'(wptr_gray), 4'b0001);

`ifdef ALMOST_FULL_EN
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 0);
    check("t6_af_at5", int'(almost_full), 0);
    cyc(1'b1, 0);
    check("t6_count6", int'(wr_count),    6);
    check("t6_af_at6", int'(almost_full), 1);
`endif

    // Randomised traffic; reader speed varies per phase to reach full and empty.
    do_reset();
    rdp = 3;
    for (int i = 0; i < 600; i++) begin
      int nrb;
      if (i % 60 == 0) rdp = $urandom_range(0, 4);
      nrb = rb;
      if (rdp != 0 && ($urandom % 4) < rdp && rb != m_wbin) nrb = (rb + 1) % MODP;
      cyc(($urandom % 4) != 0, nrb);
    end

    wr_en = 1'b0;
    @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
